// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch requester and the load/store requester.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-low reset
//   if_req_i/if_addr_i        fetch request and word address
//   if_flush_i                discard the in-flight fetch response
//   if_gnt_o                  fetch granted this cycle (combinational)
//   if_rvalid_o/if_rdata_o    fetch response, one cycle after the grant
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  load/store request
//   d_gnt_o                   data granted this cycle (combinational)
//   d_rvalid_o/d_rdata_o      load response, one cycle after the grant
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  shared memory drive
//   mem_rdata_i               memory read data (one cycle after enable)
//   busy_o                    a read response is due this cycle
module mem_port_arbiter #(
  parameter int unsigned AddressWidth  = 10,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned MaxDataStreak = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [AddressWidth-1:0] if_addr_i,
  input  logic                    if_flush_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DataWidth-1:0]    if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [AddressWidth-1:0] d_addr_i,
  input  logic [DataWidth-1:0]    d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DataWidth-1:0]    d_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned StreakWidth = 4;
  localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxDataStreak);

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  owner_e                 owner_q, owner_d;
  logic [StreakWidth-1:0] streak_q, streak_d;
  logic                   flush_pending_q, flush_pending_d;
  logic                   if_gnt, d_gnt;

  // Grant selection; held off while reset is asserted so every output reads 0.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_i) begin
      if (d_req_i && (!if_req_i || (streak_q < StreakMax))) begin
        d_gnt = 1'b1;
      end else if (if_req_i) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Next-state for response owner, data streak and flush tracking.
  always_comb begin
    owner_d         = OwnNone;
    streak_d        = streak_q;
    flush_pending_d = 1'b0;

    if (if_gnt) begin
      owner_d = OwnIf;
    end else if (d_gnt && !d_we_i) begin
      owner_d = OwnD;
    end

    // Streak only counts data grants that made a waiting fetch wait longer.
    if (if_gnt || !if_req_i) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < StreakMax)) begin
      streak_d = streak_q + StreakWidth'(1);
    end

    flush_pending_d = if_flush_i && (if_gnt || (owner_q == OwnIf));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q         <= OwnNone;
      streak_q        <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      owner_q         <= owner_d;
      streak_q        <= streak_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // Memory drive is all-zero whenever nothing is granted.
  always_comb begin
    mem_en_o    = if_gnt | d_gnt;
    mem_we_o    = d_gnt & d_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt) begin
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt) begin
      mem_addr_o = if_addr_i;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign d_gnt_o     = d_gnt;
  assign if_rvalid_o = (owner_q == OwnIf) & ~flush_pending_q;
  assign d_rvalid_o  = (owner_q == OwnD);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
  assign busy_o      = (owner_q != OwnNone);

endmodule
